// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//
// Test-pattern generator/injector on an AXI4-Stream video path.
// The input timing (tvalid, tlast, tuser) always passes through one output
// register stage. The pixel data is either forwarded unchanged or replaced by
// a pattern computed from per-frame x/y coordinates. The pattern is chosen by
// a mode that only takes effect on a start-of-frame beat.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mode                  requested pattern: 0 pass, 1 ramp, 2 bars, 3 checker,
//                         4 solid, 5-7 pass
//   solid_color           {R,B,G} colour used by the solid pattern
//   err_clr               clears the sticky line_err flag
//   s_axis_video_*        input stream (tuser = start of frame, tlast = end of line)
//   m_axis_video_*        output stream, registered, full backpressure
//   frame_cnt             count of accepted start-of-frame beats (wraps)
//   line_err              sticky flag: a line length differed from the first line
//
// Pixel packing: G in [COMP_W-1:0], B in [2*COMP_W-1:COMP_W],
// R in [3*COMP_W-1:2*COMP_W], remaining upper bits zero.

module video_pattern_gen #(
    parameter int DATA_W    = 32,
    parameter int COMP_W    = 10,
    parameter int CNT_W     = 12,
    parameter int BAR_SHIFT = 7,
    parameter int CHK_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mode,
    input  logic [3*COMP_W-1:0]   solid_color,
    input  logic                  err_clr,
    input  logic [DATA_W-1:0]     s_axis_video_tdata,
    input  logic                  s_axis_video_tvalid,
    output logic                  s_axis_video_tready,
    input  logic                  s_axis_video_tlast,
    input  logic                  s_axis_video_tuser,
    output logic [DATA_W-1:0]     m_axis_video_tdata,
    output logic                  m_axis_video_tvalid,
    input  logic                  m_axis_video_tready,
    output logic                  m_axis_video_tlast,
    output logic                  m_axis_video_tuser,
    output logic [15:0]           frame_cnt,
    output logic                  line_err
);

    typedef enum logic [2:0] {
        MODE_PASS    = 3'd0,
        MODE_RAMP    = 3'd1,
        MODE_BARS    = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_SOLID   = 3'd4
    } mode_e;

    logic [2:0]        active_mode;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [CNT_W:0]    line_len;
    logic              len_valid;

    logic              accept;
    logic [CNT_W-1:0]  ex;
    logic [CNT_W-1:0]  ey;
    logic [2:0]        eff_mode;
    logic [CNT_W:0]    ex_len;
    logic              len_valid_eff;
    logic              len_mismatch;

    logic [COMP_W-1:0] comp_x;
    logic [COMP_W-1:0] comp_y;
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
    logic [2:0]        bar_idx;
    logic              chk_on;
    logic              use_pattern;
    logic [DATA_W-1:0] packed_rgb;
    logic [DATA_W-1:0] pixel;

    // Input is ready whenever the single output slot is empty or draining
    // this cycle; held low during reset so nothing is accepted then.
    assign s_axis_video_tready = !rst && (!m_axis_video_tvalid || m_axis_video_tready);
    assign accept = s_axis_video_tvalid && s_axis_video_tready;

    // A start-of-frame beat is always coordinate (0,0) of the new frame and
    // already uses the newly requested mode, so its effective values bypass
    // the stored registers.
    assign ex            = s_axis_video_tuser ? '0 : x;
    assign ey            = s_axis_video_tuser ? '0 : y;
    assign eff_mode      = s_axis_video_tuser ? mode : active_mode;
    assign len_valid_eff = s_axis_video_tuser ? 1'b0 : len_valid;

    // Line length is one wider than the counter so a full-width line length
    // is still representable.
    assign ex_len       = {1'b0, ex} + {{CNT_W{1'b0}}, 1'b1};
    assign len_mismatch = accept && s_axis_video_tlast && len_valid_eff && (ex_len != line_len);

    // Ramp components are the low coordinate bits, zero-extended when the
    // counters are narrower than a colour component.
    generate
        if (CNT_W >= COMP_W) begin : g_comp_trunc
            assign comp_x = ex[COMP_W-1:0];
            assign comp_y = ey[COMP_W-1:0];
        end else begin : g_comp_ext
            assign comp_x = {{(COMP_W-CNT_W){1'b0}}, ex};
            assign comp_y = {{(COMP_W-CNT_W){1'b0}}, ey};
        end
    endgenerate

    // Inverting the bar number makes bar 0 white (all components on) and
    // the last of each group of eight black.
    assign bar_idx = ~ex[BAR_SHIFT+2 -: 3];
    assign chk_on  = ex[CHK_SHIFT] ^ ey[CHK_SHIFT];

    // Pattern selection: every pattern fills the three colour components,
    // pass (and the unused mode codes) forwards the input word untouched.
    always_comb begin
        r           = '0;
        g           = '0;
        b           = '0;
        use_pattern = 1'b1;
        case (eff_mode)
            MODE_RAMP: begin
                g = comp_x;
                b = comp_y;
                r = ~comp_y;
            end
            MODE_BARS: begin
                r = {COMP_W{bar_idx[2]}};
                g = {COMP_W{bar_idx[1]}};
                b = {COMP_W{bar_idx[0]}};
            end
            MODE_CHECKER: begin
                r = {COMP_W{chk_on}};
                g = {COMP_W{chk_on}};
                b = {COMP_W{chk_on}};
            end
            MODE_SOLID: begin
                {r, b, g} = solid_color;
            end
            default: begin
                use_pattern = 1'b0;
            end
        endcase
        packed_rgb                 = '0;
        packed_rgb[3*COMP_W-1:0]   = {r, b, g};
        pixel                      = use_pattern ? packed_rgb : s_axis_video_tdata;
    end

    // Output register stage: load on accept, otherwise drop valid once the
    // downstream has taken the held beat. Reset discards any in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_video_tdata  <= '0;
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
            m_axis_video_tuser  <= 1'b0;
        end else if (accept) begin
            m_axis_video_tdata  <= pixel;
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tlast  <= s_axis_video_tlast;
            m_axis_video_tuser  <= s_axis_video_tuser;
        end else if (m_axis_video_tready) begin
            m_axis_video_tvalid <= 1'b0;
        end
    end

    // Frame bookkeeping: coordinates, latched mode and frame count all move
    // only on accepted beats. x/y wrap silently at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            active_mode <= MODE_PASS;
            frame_cnt   <= '0;
        end else if (accept) begin
            if (s_axis_video_tlast) begin
                x <= '0;
                y <= ey + CNT_W'(1);
            end else begin
                x <= ex + CNT_W'(1);
                y <= ey;
            end
            if (s_axis_video_tuser) begin
                active_mode <= eff_mode;
                frame_cnt   <= frame_cnt + 16'd1;
            end
        end
    end

    // Line-length checker: the first complete line of each frame sets the
    // reference length, later lines are compared against it. A new mismatch
    // takes priority over a simultaneous clear so an error is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_len  <= '0;
            len_valid <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            if (accept) begin
                if (s_axis_video_tlast && !len_valid_eff) begin
                    line_len  <= ex_len;
                    len_valid <= 1'b1;
                end else if (s_axis_video_tuser) begin
                    len_valid <= 1'b0;
                end
            end
            if (len_mismatch) begin
                line_err <= 1'b1;
            end else if (err_clr) begin
                line_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//
// Directed bench for video_pattern_gen. The DUT is built with narrow bars and
// checker cells (BAR_SHIFT=1, CHK_SHIFT=1) so short lines show every pattern
// transition. Each test task drives its own beats and compares outputs
// against hand-computed values.

module tb_video_pattern_gen;

    localparam int DATA_W    = 32;
    localparam int COMP_W    = 10;
    localparam int CNT_W     = 12;
    localparam int BAR_SHIFT = 1;
    localparam int CHK_SHIFT = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          mode = 3'd0;
    logic [3*COMP_W-1:0] solid_color = '0;
    logic                err_clr = 1'b0;
    logic [DATA_W-1:0]   s_tdata = '0;
    logic                s_tvalid = 1'b0;
    logic                s_tready;
    logic                s_tlast = 1'b0;
    logic                s_tuser = 1'b0;
    logic [DATA_W-1:0]   m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic                m_tlast;
    logic                m_tuser;
    logic [15:0]         frame_cnt;
    logic                line_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;

    logic [31:0] pass_data [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'h0000_0001,
                                   32'hFFFF_FFFF, 32'h1357_9BDF, 32'h2468_ACE0, 32'h5A5A_A5A5};
    logic [31:0] bar_color [8] = '{32'h3FFF_FFFF, 32'h3FF0_03FF, 32'h3FFF_FC00, 32'h3FF0_0000,
                                   32'h000F_FFFF, 32'h0000_03FF, 32'h000F_FC00, 32'h0000_0000};

    video_pattern_gen #(
        .DATA_W    (DATA_W),
        .COMP_W    (COMP_W),
        .CNT_W     (CNT_W),
        .BAR_SHIFT (BAR_SHIFT),
        .CHK_SHIFT (CHK_SHIFT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mode                (mode),
        .solid_color         (solid_color),
        .err_clr             (err_clr),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tuser  (s_tuser),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tuser  (m_tuser),
        .frame_cnt           (frame_cnt),
        .line_err            (line_err)
    );

    always #5 clk = ~clk;

    // Ramp reference: G = x, B = y, R = ~y, 10 bits each.
    function automatic logic [31:0] ramp_px(input int xx, input int yy);
        logic [9:0] gv;
        logic [9:0] bv;
        gv = 10'(xx);
        bv = 10'(yy);
        return {2'b00, ~bv, bv, gv};
    endfunction

    // Checker reference for 2-pixel cells.
    function automatic logic [31:0] checker_px(input int xx, input int yy);
        return ((((xx >> 1) ^ (yy >> 1)) & 1) != 0) ? 32'h3FFF_FFFF : 32'h0000_0000;
    endfunction

    // Present one beat, let the next rising edge take it, then look 1 ns
    // later at what the output register now holds.
    task automatic drive_beat(input logic [31:0] d, input logic u, input logic l);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s_tvalid = 1'b1;
        s_tuser  = 1'b1;
        s_tdata  = 32'hCAFE_F00D;
        #1;
        vectors++;
        if (s_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_tready: got %b want 0", s_tready);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({m_tvalid, m_tlast, m_tuser} !== 3'b000 || m_tdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v%b l%b u%b d%h want all 0",
                     m_tvalid, m_tlast, m_tuser, m_tdata);
        end
        vectors++;
        if (frame_cnt !== 16'd0 || line_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got frame_cnt %0d line_err %b want 0 0", frame_cnt, line_err);
        end
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        #1;
        vectors++;
        if (s_tready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_tready: got %b want 1", s_tready);
        end
    endtask

    task automatic test_pass();
        logic u;
        logic l;
        mode = 3'd0;
        for (int i = 0; i < 8; i++) begin
            u = (i == 0);
            l = (i == 3) || (i == 7);
            drive_beat(pass_data[i], u, l);
            vectors++;
            if (m_tdata !== pass_data[i] || m_tvalid !== 1'b1 || m_tuser !== u || m_tlast !== l) begin
                miscompares++;
                $display("[TB] FAIL pass_beat%0d: got d%h v%b u%b l%b want d%h v1 u%b l%b",
                         i, m_tdata, m_tvalid, m_tuser, m_tlast, pass_data[i], u, l);
            end
        end
        exp_frames++;
        vectors++;
        if (frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("[TB] FAIL pass_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_ramp();
        mode = 3'd1;
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                drive_beat(32'hDEAD_BEEF, (xx == 0 && yy == 0), (xx == 3));
                vectors++;
                if (m_tdata !== ramp_px(xx, yy)) begin
                    miscompares++;
                    $display("[TB] FAIL ramp_x%0d_y%0d: got %h want %h", xx, yy, m_tdata, ramp_px(xx, yy));
                end
                if (xx == 2 && yy == 1) begin
                    vectors++;
                    if (m_tdata !== 32'h3FE0_0402) begin
                        miscompares++;
                        $display("[TB] FAIL ramp_x2_y1_const: got %h want 3fe00402", m_tdata);
                    end
                end
            end
        end
        exp_frames++;
        vectors++;
        if (line_err !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("[TB] FAIL ramp_status: got line_err %b frame_cnt %0d want 0 %0d",
                     line_err, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_bars();
        mode = 3'd2;
        for (int i = 0; i < 16; i++) begin
            drive_beat(32'h1111_1111, (i == 0), (i == 15));
            vectors++;
            if (m_tdata !== bar_color[i/2]) begin
                miscompares++;
                $display("[TB] FAIL bars_px%0d: got %h want %h", i, m_tdata, bar_color[i/2]);
            end
        end
        exp_frames++;
    endtask

    task automatic test_mode_switch();
        mode = 3'd1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) mode = 3'd3;
            drive_beat(32'h0, (i == 0), (i % 4 == 3));
            vectors++;
            if (m_tdata !== ramp_px(i % 4, i / 4)) begin
                miscompares++;
                $display("[TB] FAIL switch_ramp_px%0d: got %h want %h", i, m_tdata, ramp_px(i % 4, i / 4));
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive_beat(32'h0, (i == 0), (i % 4 == 3));
            vectors++;
            if (m_tdata !== checker_px(i % 4, i / 4)) begin
                miscompares++;
                $display("[TB] FAIL switch_checker_px%0d: got %h want %h", i, m_tdata, checker_px(i % 4, i / 4));
            end
        end
        exp_frames += 2;
        vectors++;
        if (frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("[TB] FAIL switch_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        mode     = 3'd0;
        m_tready = 1'b1;
        s_tdata  = 32'hAAAA_0001;
        s_tuser  = 1'b1;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (m_tdata !== 32'hAAAA_0001 || m_tvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_first: got d%h v%b want aaaa0001 v1", m_tdata, m_tvalid);
        end
        s_tdata  = 32'hBBBB_0002;
        s_tuser  = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (s_tready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_stall_tready%0d: got %b want 0", i, s_tready);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (m_tdata !== 32'hAAAA_0001 || m_tvalid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got d%h v%b want aaaa0001 v1", i, m_tdata, m_tvalid);
            end
        end
        m_tready = 1'b1;
        #1;
        vectors++;
        if (s_tready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release_tready: got %b want 1", s_tready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (m_tdata !== 32'hBBBB_0002 || m_tvalid !== 1'b1 || m_tuser !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_second: got d%h v%b u%b want bbbb0002 v1 u0", m_tdata, m_tvalid, m_tuser);
        end
        s_tdata = 32'hCCCC_0003;
        s_tlast = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (m_tdata !== 32'hCCCC_0003 || m_tlast !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_third: got d%h l%b want cccc0003 l1", m_tdata, m_tlast);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (m_tvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_drain: got v%b want v0", m_tvalid);
        end
        exp_frames++;
    endtask

    task automatic test_line_check();
        int lens [3] = '{4, 4, 3};
        logic exp_err;
        mode = 3'd0;
        for (int ln = 0; ln < 3; ln++) begin
            for (int i = 0; i < lens[ln]; i++) begin
                drive_beat(32'h0, (ln == 0 && i == 0), (i == lens[ln] - 1));
            end
            exp_err = (ln == 2);
            vectors++;
            if (line_err !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL linechk_line%0d: got %b want %b", ln, line_err, exp_err);
            end
        end
        drive_beat(32'h0, 1'b0, 1'b0);
        err_clr = 1'b1;
        drive_beat(32'h0, 1'b0, 1'b1);
        err_clr = 1'b0;
        vectors++;
        if (line_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL linechk_set_wins: got %b want 1", line_err);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        vectors++;
        if (line_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL linechk_clear: got %b want 0", line_err);
        end
        exp_frames++;
    endtask

    task automatic test_one_pixel_line();
        mode = 3'd1;
        drive_beat(32'h0, 1'b1, 1'b1);
        vectors++;
        if (m_tdata !== 32'h3FF0_0000 || m_tuser !== 1'b1 || m_tlast !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL onepix_first: got d%h u%b l%b want 3ff00000 u1 l1", m_tdata, m_tuser, m_tlast);
        end
        drive_beat(32'h0, 1'b0, 1'b1);
        vectors++;
        if (m_tdata !== 32'h3FE0_0400 || line_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL onepix_second: got d%h err%b want 3fe00400 err0", m_tdata, line_err);
        end
        drive_beat(32'h0, 1'b0, 1'b0);
        drive_beat(32'h0, 1'b0, 1'b1);
        vectors++;
        if (m_tdata !== 32'h3FD0_0801 || line_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL onepix_long_line: got d%h err%b want 3fd00801 err1", m_tdata, line_err);
        end
        exp_frames++;
        vectors++;
        if (frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("[TB] FAIL onepix_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        mode = 3'd1;
        drive_beat(32'h0, 1'b1, 1'b0);
        drive_beat(32'h0, 1'b0, 1'b0);
        rst      = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'h7777_7777;
        #1;
        vectors++;
        if (s_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_tready: got %b want 0", s_tready);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        vectors++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || frame_cnt !== 16'd0 || line_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got v%b d%h fc%0d err%b want v0 d0 fc0 err0",
                     m_tvalid, m_tdata, frame_cnt, line_err);
        end
        drive_beat(32'h1234_5678, 1'b0, 1'b0);
        vectors++;
        if (m_tdata !== 32'h1234_5678 || m_tvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_pass_mode: got d%h v%b want 12345678 v1", m_tdata, m_tvalid);
        end
        drive_beat(32'h0, 1'b1, 1'b0);
        vectors++;
        if (m_tdata !== 32'h3FF0_0000 || frame_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL midrst_new_frame: got d%h fc%0d want 3ff00000 fc1", m_tdata, frame_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_pass();
        test_ramp();
        test_bars();
        test_mode_switch();
        test_backpressure();
        test_line_check();
        test_one_pixel_line();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
